vec_mem_sequencer: RTL

Multi-cycle sequencer for the vector memory instructions VLDH (vector load) and VSTB (vector store). When decode issues a vector memory op, the block stalls the scalar pipeline and walks the vector lanes, issuing one element access per lane to the data memory port over a req/ack handshake. For loads it assembles the elements into a full vector and writes it to the vector register file; for stores it serialises the vector read from the register file. It sits between the decode/control stage and the data memory, next to the vector register file write port.

---
 rtl/vec_mem_sequencer.sv | 104 ++++++++++
 1 files changed

// File: rtl/vec_mem_sequencer.sv
// Vector load/store sequencer: walks LANES element accesses over a req/ack
// memory port, assembling loads into a vector and serialising stores.
//   state | meaning
//   IDLE  | no access in progress
//   ISSUE | one element access outstanding for lane idx
//   FIN   | completion cycle, done (and vec_we for loads)
module vec_mem_sequencer #(
  parameter int LANES  = 4,
  parameter int ELEM_W = 16,
  parameter int ADDR_W = 32,
  parameter int STRIDE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    is_store,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [LANES*ELEM_W-1:0] vec_wdata,
  input  logic                    abort,
  output logic                    busy,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [ELEM_W-1:0]       mem_wdata,
  input  logic                    mem_ack,
  input  logic [ELEM_W-1:0]       mem_rdata,
  output logic [LANES*ELEM_W-1:0] vec_rdata,
  output logic                    vec_we,
  output logic                    done
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, FIN} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q;
  logic                    store_q;
  logic [ADDR_W-1:0]       base_q;
  logic [LANES*ELEM_W-1:0] wdata_q;
  logic [LANES*ELEM_W-1:0] buf_q;
  logic                    accept;
  logic                    xfer;
  logic                    last;

  assign accept = (state_q == IDLE) && start && !abort;
  assign xfer   = (state_q == ISSUE) && mem_ack;
  assign last   = (idx_q == IDX_W'(LANES - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   if (xfer && last) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      store_q <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      if (abort) begin
        idx_q <= '0;
      end else if (accept) begin
        idx_q   <= '0;
        store_q <= is_store;
        base_q  <= base_addr;
        wdata_q <= vec_wdata;
        if (!is_store) buf_q <= '0;
      end else if (xfer) begin
        if (!store_q) buf_q[idx_q*ELEM_W +: ELEM_W] <= mem_rdata;
        if (!last) idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  // Memory-side outputs decode registered state only; they read 0 outside ISSUE.
  always_comb begin
    mem_req   = (state_q == ISSUE);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_req) begin
      mem_we    = store_q;
      mem_addr  = base_q + ADDR_W'(idx_q) * ADDR_W'(STRIDE);
      mem_wdata = wdata_q[idx_q*ELEM_W +: ELEM_W];
    end
  end

  assign busy      = rst && (start || (state_q != IDLE));
  assign done      = (state_q == FIN);
  assign vec_we    = (state_q == FIN) && !store_q;
  assign vec_rdata = buf_q;

endmodule
